// File: rtl/smg_pkg.sv
// Shared widths, codes and FSM encoding for the seven-segment scan controller.
// Also hosts the per-digit display code function used by the top.
package smg_pkg;

   localparam int unsigned SEL_W      = 2;
   localparam int unsigned DIG_W      = 4;
   localparam int unsigned NUM_DIG    = 4;
   localparam logic [3:0]  BLANK_CODE = 4'hF;

   typedef enum logic [0:0] {
      StBlank = 1'b0,
      StShow  = 1'b1
   } scan_state_e;

   // Digit code for position sel; with lz_en, a zero digit whose higher digits are all zero
   // is blanked, except the rightmost digit which always shows.
   function automatic logic [DIG_W-1:0] digit_code(
      input logic [NUM_DIG*DIG_W-1:0] value,
      input logic [SEL_W-1:0]         sel,
      input logic                     lz_en
   );
      logic [DIG_W-1:0] nib;
      logic             upper_zero;
      nib        = value[sel*DIG_W +: DIG_W];
      upper_zero = 1'b1;
      for (int i = 0; i < int'(NUM_DIG); i++) begin
         if (i >= int'(sel) && value[i*DIG_W +: DIG_W] != '0) begin
            upper_zero = 1'b0;
         end
      end
      if (lz_en && (sel != '0) && upper_zero) begin
         return BLANK_CODE;
      end
      return nib;
   endfunction

endpackage

// File: rtl/scan_slot_timer.sv
// Free-running slot counter 0..SCAN_DIV-1 with strobes on the last blanking cycle and on
// the last cycle of the slot.
module scan_slot_timer #(
   parameter int unsigned SCAN_DIV  = 12000,
   parameter int unsigned BLANK_CYC = 600
) (
   input  logic clk,
   input  logic rst,
   output logic blank_end,
   output logic slot_end
);

   localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC == 0) ? 0 : BLANK_CYC - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      slot_end = (cnt_q == CNT_LAST);
      // With no blanking interval the BLANK state must be left immediately.
      blank_end = (BLANK_CYC == 0) || (cnt_q == BLANK_LAST);
      cnt_d = slot_end ? '0 : cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/smg_scan_ctrl.sv
// Four-digit seven-segment scan controller: slot timing, blanking, leading-zero suppression
// and a frame-synchronous shadow register loaded over a valid/ready handshake.
module smg_scan_ctrl
   import smg_pkg::*;
#(
   parameter int unsigned SCAN_DIV  = 12000,
   parameter int unsigned BLANK_CYC = 600
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_DIG*DIG_W-1:0] upd_data,
   input  logic                     upd_valid,
   output logic                     upd_ready,
   input  logic                     lz_en,
   output logic [SEL_W-1:0]         sel,
   output logic [DIG_W-1:0]         key,
   output logic                     frame_done
);

   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_DIG - 1);

   logic blank_end, slot_end, accept;

   scan_state_e                state_q, state_d;
   logic [SEL_W-1:0]           sel_q, sel_d;
   logic [DIG_W-1:0]           key_q, key_d;
   logic                       frame_done_q, frame_done_d;
   logic [NUM_DIG*DIG_W-1:0]   active_q, active_d;
   logic [NUM_DIG*DIG_W-1:0]   shadow_q, shadow_d;
   logic                       pending_q, pending_d;

   scan_slot_timer #(
      .SCAN_DIV  (SCAN_DIV),
      .BLANK_CYC (BLANK_CYC)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .blank_end (blank_end),
      .slot_end  (slot_end)
   );

   assign upd_ready = ~pending_q;
   assign accept    = upd_valid & ~pending_q;

   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      active_d     = active_q;
      shadow_d     = shadow_q;
      pending_d    = pending_q;
      frame_done_d = 1'b0;

      unique case (state_q)
         StBlank: if (blank_end) state_d = StShow;
         StShow:  state_d = StShow;
         default: state_d = StBlank;
      endcase

      if (slot_end) begin
         sel_d   = sel_q + SEL_W'(1);
         state_d = (BLANK_CYC == 0) ? StShow : StBlank;
         if (sel_q == SEL_LAST) begin
            frame_done_d = 1'b1;
            if (pending_q) begin
               active_d  = shadow_q;
               pending_d = 1'b0;
            end
         end
      end

      // accept only fires with pending_q low, so it never collides with the swap above.
      if (accept) begin
         shadow_d  = upd_data;
         pending_d = 1'b1;
      end

      // key is computed from next-state values so it lines up with the registered sel.
      key_d = (state_d == StShow) ? digit_code(active_d, sel_d, lz_en) : BLANK_CODE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StBlank;
         sel_q        <= '0;
         key_q        <= BLANK_CODE;
         frame_done_q <= 1'b0;
         active_q     <= '0;
         shadow_q     <= '0;
         pending_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         key_q        <= key_d;
         frame_done_q <= frame_done_d;
         active_q     <= active_d;
         shadow_q     <= shadow_d;
         pending_q    <= pending_d;
      end
   end

   assign sel        = sel_q;
   assign key        = key_q;
   assign frame_done = frame_done_q;

endmodule
